// File: rtl/exe_stage.sv
// exe_stage: execute stage with single-cycle ALU/shift/LUI/JAL, iterative radix-2 restoring DIV/DIVU and optional signed MULT
//   Optional feature macro: EXE_MULT_EN (defined: single-cycle signed MULT on i_ALUControl[14]; undefined: that bit is a NOP)
//   Ports: clk, reset (async, active-low), stall[5:0] (stall[3] holds EXE/MEM), i_flush,
//          i_pc, i_da, i_db, i_imm, i_aluimm, i_shift, i_jal, i_ALUControl[14:0] (one-hot op select),
//          o_alu_result, o_stallreq, o_div_busy, o_hilo_we, o_hi, o_lo
module exe_stage #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_da,
  input  logic [31:0] i_db,
  input  logic [31:0] i_imm,
  input  logic        i_aluimm,
  input  logic        i_shift,
  input  logic        i_jal,
  input  logic [14:0] i_ALUControl,
  output logic [31:0] o_alu_result,
  output logic        o_stallreq,
  output logic        o_div_busy,
  output logic        o_hilo_we,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]  state;
  logic [5:0]  count;
  logic [63:0] rq;
  logic [31:0] dvs;
  logic        q_neg, r_neg;
  logic [31:0] a, b, a_mag, b_mag, quo, rem;
  logic [4:0]  sa;
  logic        div_op, div_sgn, issue, ge, mult_v;
  logic [32:0] top, trial;
  logic [63:0] prod;
  logic        unused_ok;
  assign a = i_da;
  assign b = i_aluimm ? i_imm : i_db;
  assign sa = i_shift ? i_imm[10:6] : i_da[4:0];
  assign o_alu_result = i_jal ? i_pc + 32'd8 :
    i_ALUControl[0]  ? a + b :
    i_ALUControl[1]  ? a - b :
    i_ALUControl[2]  ? a & b :
    i_ALUControl[3]  ? a | b :
    i_ALUControl[4]  ? a ^ b :
    i_ALUControl[5]  ? ~(a | b) :
    i_ALUControl[6]  ? {31'h0, $signed(a) < $signed(b)} :
    i_ALUControl[7]  ? {31'h0, a < b} :
    i_ALUControl[8]  ? b << sa :
    i_ALUControl[9]  ? b >> sa :
    i_ALUControl[10] ? $unsigned($signed(b) >>> sa) :
    i_ALUControl[11] ? {b[15:0], 16'h0} : 32'h0;
  assign div_op = i_ALUControl[12] | i_ALUControl[13];
  assign div_sgn = i_ALUControl[12];
  assign issue = reset && state == IDLE && div_op && !i_flush;
  assign a_mag = div_sgn && a[31] ? -a : a;
  assign b_mag = div_sgn && b[31] ? -b : b;
  // partial remainder is always below the divisor, so the shifted value fits 33 bits
  assign top = rq[63:31];
  assign ge = top >= {1'b0, dvs};
  assign trial = top - {1'b0, dvs};
  assign quo = q_neg ? -rq[31:0] : rq[31:0];
  assign rem = r_neg ? -rq[63:32] : rq[63:32];
`ifdef EXE_MULT_EN
  logic signed [63:0] ax, bx;
  assign ax = {{32{a[31]}}, a};
  assign bx = {{32{b[31]}}, b};
  assign prod = ax * bx;
  assign mult_v = reset && i_ALUControl[14];
`else
  assign prod = 64'h0;
  assign mult_v = 1'b0;
`endif
  assign unused_ok = ^{stall[5:4], stall[2:0], i_ALUControl[14]};
  assign o_div_busy = state != IDLE;
  assign o_stallreq = !i_flush && (issue || state == BUSY);
  assign o_hilo_we = !i_flush && (state == DONE || mult_v);
  assign o_hi = state == DONE ? rem : mult_v ? prod[63:32] : 32'h0;
  assign o_lo = state == DONE ? quo : mult_v ? prod[31:0] : 32'h0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      rq <= '0;
      dvs <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (i_flush) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (div_op) begin
        // divide by zero skips BUSY and reports HI = dividend, LO = all ones
        state <= b == 32'h0 ? DONE : BUSY;
        count <= '0;
        rq <= b == 32'h0 ? {a, 32'hFFFF_FFFF} : {32'h0, a_mag};
        dvs <= b_mag;
        q_neg <= div_sgn && b != 32'h0 && (a[31] ^ b[31]);
        r_neg <= div_sgn && b != 32'h0 && a[31];
      end
    end else if (state == BUSY) begin
      rq <= {ge ? trial[31:0] : top[31:0], rq[30:0], ge};
      count <= count + 6'd1;
      if (count == 6'(DIV_ITER - 1)) state <= DONE;
    end else if (!stall[3]) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized self-checking bench for exe_stage against an arithmetic reference model
module tb_exe_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  stall = '0;
  logic        i_flush = 1'b0, i_aluimm = 1'b0, i_shift = 1'b0, i_jal = 1'b0;
  logic [31:0] i_pc = '0, i_da = '0, i_db = '0, i_imm = '0;
  logic [14:0] i_ALUControl = '0;
  logic [31:0] o_alu_result, o_hi, o_lo;
  logic        o_stallreq, o_div_busy, o_hilo_we;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .i_flush(i_flush), .i_pc(i_pc),
    .i_da(i_da), .i_db(i_db), .i_imm(i_imm), .i_aluimm(i_aluimm), .i_shift(i_shift),
    .i_jal(i_jal), .i_ALUControl(i_ALUControl), .o_alu_result(o_alu_result),
    .o_stallreq(o_stallreq), .o_div_busy(o_div_busy), .o_hilo_we(o_hilo_we),
    .o_hi(o_hi), .o_lo(o_lo)
  );

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sa);
    int s;
    s = b;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ~(a | b);
      6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      7: return (a < b) ? 32'd1 : 32'd0;
      8: return b * (32'd1 << sa);
      9: return b / (32'd1 << sa);
      10: return s >>> sa;
      11: return b * 32'h10000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_stallreq, o_div_busy, o_hilo_we, o_hi, o_lo, o_alu_result} !== 99'h0) begin
      errors++;
      $display("FAIL reset_state got stallreq=%b busy=%b we=%b hi=%h lo=%h res=%h exp all 0", o_stallreq, o_div_busy, o_hilo_we, o_hi, o_lo, o_alu_result);
    end
    i_ALUControl = 15'h1; i_da = 32'd1; i_db = 32'd2;
    #1;
    checks++;
    if (o_alu_result !== 32'd3) begin errors++; $display("FAIL reset_alu_comb got=%h exp=%h", o_alu_result, 32'd3); end
    i_ALUControl = 15'h1000;
    #1;
    checks++;
    if ({o_stallreq, o_div_busy} !== 2'b00) begin errors++; $display("FAIL reset_div_nostall got stallreq=%b busy=%b exp 0 0", o_stallreq, o_div_busy); end
    i_ALUControl = 15'h0;
    #1 reset = 1'b1;
  endtask

  task automatic test_alu_directed;
    int          ops[6]  = '{0, 6, 7, 10, 0, 12};
    logic [31:0] das[6]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h5, 32'h9};
    logic [31:0] dbs[6]  = '{32'h1, 32'h0, 32'h0, 32'h8000_0000, 32'h6, 32'h3};
    logic        shs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        jals[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps[6] = '{32'h8000_0000, 32'h1, 32'h0, 32'hF800_0000, 32'h0040_0008, 32'h0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      i_ALUControl = ops[i] == 12 ? 15'h0 : 15'd1 << ops[i];
      i_da = das[i]; i_db = dbs[i]; i_shift = shs[i]; i_jal = jals[i];
      i_imm = 32'd4 << 6; i_aluimm = 1'b0; i_pc = 32'h0040_0000;
      @(negedge clk);
      checks++;
      if ({o_alu_result, o_stallreq, o_hilo_we} !== {exps[i], 2'b00}) begin
        errors++;
        $display("FAIL alu_directed idx=%0d got res=%h stallreq=%b we=%b exp res=%h 0 0", i, o_alu_result, o_stallreq, o_hilo_we, exps[i]);
      end
    end
    i_jal = 1'b0; i_shift = 1'b0; i_ALUControl = 15'h0;
  endtask

  task automatic test_alu_random;
    int op;
    logic [31:0] b, exp;
    logic [4:0] sa;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      op = $urandom_range(0, 12);
      i_da = $urandom; i_db = $urandom; i_imm = $urandom; i_pc = $urandom;
      i_aluimm = $urandom_range(0, 1); i_shift = $urandom_range(0, 1);
      i_jal = $urandom_range(0, 7) == 0;
      i_ALUControl = op == 12 ? 15'h0 : 15'd1 << op;
      b = i_aluimm ? i_imm : i_db;
      sa = i_shift ? i_imm[10:6] : i_da[4:0];
      exp = i_jal ? i_pc + 32'd8 : ref_alu(op, i_da, b, sa);
      @(negedge clk);
      checks++;
      if ({o_alu_result, o_stallreq, o_hilo_we, o_div_busy} !== {exp, 3'b000}) begin
        errors++;
        $display("FAIL alu_random op=%0d a=%h b=%h sa=%0d jal=%b got res=%h flags=%b%b%b exp res=%h flags=000", op, i_da, b, sa, i_jal, o_alu_result, o_stallreq, o_hilo_we, o_div_busy, exp);
      end
    end
    i_jal = 1'b0; i_shift = 1'b0; i_aluimm = 1'b0; i_ALUControl = 15'h0;
  endtask

  task automatic div_case(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] eh, el;
    longint q, r;
    int lat;
    if (b == 32'h0) begin
      eh = a; el = 32'hFFFF_FFFF;
    end else if (sgn) begin
      q = longint'(int'(a)) / longint'(int'(b));
      r = longint'(int'(a)) % longint'(int'(b));
      eh = r[31:0]; el = q[31:0];
    end else begin
      q = longint'({32'h0, a}) / longint'({32'h0, b});
      r = longint'({32'h0, a}) % longint'({32'h0, b});
      eh = r[31:0]; el = q[31:0];
    end
    lat = b == 32'h0 ? 1 : 33;
    @(posedge clk); #1;
    i_ALUControl = sgn ? 15'h1000 : 15'h2000;
    i_da = a; i_db = b; i_aluimm = 1'b0; i_jal = 1'b0;
    stall = hold > 0 ? 6'b001000 : 6'b000000;
    @(negedge clk);
    checks++;
    if ({o_stallreq, o_hilo_we, o_alu_result} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL div_issue a=%h b=%h got stallreq=%b we=%b res=%h exp 1 0 00000000", a, b, o_stallreq, o_hilo_we, o_alu_result);
    end
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        i_da = $urandom; i_db = $urandom;
        if (hold == 0) i_ALUControl = 15'h0;
      end
      @(negedge clk);
      if (c < lat) begin
        checks++;
        if ({o_stallreq, o_div_busy, o_hilo_we} !== 3'b110) begin
          errors++;
          $display("FAIL div_busy cycle=%0d got stallreq=%b busy=%b we=%b exp 1 1 0", c, o_stallreq, o_div_busy, o_hilo_we);
        end
      end
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(posedge clk); #1;
        if (h == hold) begin stall = 6'b0; i_ALUControl = 15'h0; end
        @(negedge clk);
      end
      checks++;
      if ({o_stallreq, o_div_busy, o_hilo_we, o_hi, o_lo} !== {3'b011, eh, el}) begin
        errors++;
        $display("FAIL div_done sgn=%b a=%h b=%h h=%0d got stallreq=%b busy=%b we=%b hi=%h lo=%h exp 0 1 1 hi=%h lo=%h", sgn, a, b, h, o_stallreq, o_div_busy, o_hilo_we, o_hi, o_lo, eh, el);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({o_stallreq, o_div_busy, o_hilo_we, o_hi, o_lo} !== 67'h0) begin
      errors++;
      $display("FAIL div_idle got stallreq=%b busy=%b we=%b hi=%h lo=%h exp all 0", o_stallreq, o_div_busy, o_hilo_we, o_hi, o_lo);
    end
  endtask

  task automatic test_div_directed;
    div_case(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    div_case(1'b0, 32'd100, 32'd7, 0);
    div_case(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    div_case(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
  endtask

  task automatic test_div_zero;
    div_case(1'b0, 32'd5, 32'd0, 0);
    div_case(1'b1, 32'hFFFF_FF00, 32'd0, 0);
  endtask

  task automatic test_div_random;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = 32'h0;
      endcase
      div_case($urandom_range(0, 1), $urandom, b, 0);
    end
  endtask

  task automatic test_div_hold;
    div_case(1'b0, 32'd1000, 32'd33, 3);
    div_case(1'b1, 32'hFFFF_FC18, 32'd0, 2);
  endtask

  task automatic test_flush;
    @(posedge clk); #1;
    i_ALUControl = 15'h1000; i_da = 32'd100; i_db = 32'd3; i_flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_stallreq, o_hilo_we} !== 2'b00) begin errors++; $display("FAIL flush_issue got stallreq=%b we=%b exp 0 0", o_stallreq, o_hilo_we); end
    @(posedge clk); #1;
    i_flush = 1'b0; i_ALUControl = 15'h0;
    @(negedge clk);
    checks++;
    if ({o_stallreq, o_div_busy} !== 2'b00) begin errors++; $display("FAIL flush_nostart got stallreq=%b busy=%b exp 0 0", o_stallreq, o_div_busy); end
    @(posedge clk); #1;
    i_ALUControl = 15'h2000; i_da = $urandom; i_db = 32'd7;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c == 1) i_ALUControl = 15'h0;
      if (c == 11) i_flush = 1'b1;
      @(negedge clk);
      if (c == 10) begin
        checks++;
        if ({o_stallreq, o_div_busy} !== 2'b11) begin errors++; $display("FAIL flush_prebusy got stallreq=%b busy=%b exp 1 1", o_stallreq, o_div_busy); end
      end
    end
    checks++;
    if ({o_stallreq, o_hilo_we} !== 2'b00) begin errors++; $display("FAIL flush_busy got stallreq=%b we=%b exp 0 0", o_stallreq, o_hilo_we); end
    @(posedge clk); #1;
    i_flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_stallreq, o_div_busy, o_hilo_we} !== 3'b000) begin errors++; $display("FAIL flush_idle got stallreq=%b busy=%b we=%b exp 0 0 0", o_stallreq, o_div_busy, o_hilo_we); end
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    i_ALUControl = 15'h1000; i_da = 32'd12345; i_db = 32'd11;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c == 1) i_ALUControl = 15'h0;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({o_stallreq, o_div_busy, o_hilo_we, o_hi, o_lo} !== 67'h0) begin
      errors++;
      $display("FAIL async_reset got stallreq=%b busy=%b we=%b hi=%h lo=%h exp all 0", o_stallreq, o_div_busy, o_hilo_we, o_hi, o_lo);
    end
    i_ALUControl = 15'h1; i_da = 32'h1234; i_db = 32'h1111;
    #1;
    checks++;
    if (o_alu_result !== 32'h2345) begin errors++; $display("FAIL async_reset_alu got=%h exp=%h", o_alu_result, 32'h2345); end
    @(negedge clk);
    #2 reset = 1'b1;
    i_ALUControl = 15'h0;
    div_case(1'b1, 32'd77, 32'hFFFF_FFF6, 0);
  endtask

  task automatic test_mult;
    logic [31:0] as[4] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0};
    logic [31:0] bs[4] = '{32'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] a, b;
    longint p;
    for (int i = 0; i < 16; i++) begin
      a = i < 4 ? as[i] : $urandom;
      b = i < 4 ? bs[i] : $urandom;
      p = longint'(int'(a)) * longint'(int'(b));
      @(posedge clk); #1;
      i_ALUControl = 15'h4000; i_da = a; i_db = b; i_aluimm = 1'b0;
      @(negedge clk);
      checks++;
`ifdef EXE_MULT_EN
      if ({o_stallreq, o_hilo_we, o_alu_result, o_hi, o_lo} !== {2'b01, 32'h0, p[63:32], p[31:0]}) begin
        errors++;
        $display("FAIL mult a=%h b=%h got stallreq=%b we=%b res=%h hi=%h lo=%h exp 0 1 0 hi=%h lo=%h", a, b, o_stallreq, o_hilo_we, o_alu_result, o_hi, o_lo, p[63:32], p[31:0]);
      end
`else
      if ({o_stallreq, o_hilo_we, o_alu_result, o_hi, o_lo} !== 98'h0) begin
        errors++;
        $display("FAIL mult_nop a=%h b=%h prod=%h got stallreq=%b we=%b res=%h hi=%h lo=%h exp all 0", a, b, p, o_stallreq, o_hilo_we, o_alu_result, o_hi, o_lo);
      end
`endif
    end
    @(posedge clk); #1;
    i_ALUControl = 15'h0;
  endtask

  initial begin
    test_reset;
    test_alu_directed;
    test_alu_random;
    test_div_directed;
    test_div_zero;
    test_div_random;
    test_div_hold;
    test_flush;
    test_async_reset;
    test_mult;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
